// File: rtl/mem_port_master.sv
// Core-side initiator for the shared-RAM arbitration protocol.
// Takes one load/store from the core, raises rden/wren toward the arbiter until
// acq is granted, then returns read data after RD_LAT cycles.
module mem_port_master #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CW     = 16
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic          acq,
    input  logic [DW-1:0] mem_q,
    output logic          busy,
    output logic [CW-1:0] stall_cnt,
    input  logic          clr_stats
);

    typedef enum logic [1:0] {StIdle, StReq, StLat, StDone} state_e;

    // Latency counter preload: a value of 0 captures on the first LAT cycle.
    localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

    state_e          state_q, state_d;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   din_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      lat_q;
    logic [CW-1:0]   stall_q;
    logic            busy_q;

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acq is only meaningful while requesting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = StReq;
            StReq: begin
                if (acq) state_d = we_q ? StDone : StLat;
            end
            StLat:  if (lat_q == 2'd0) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        req_ready  = (state_q == StIdle);
        mem_rden   = (state_q == StReq) && !we_q;
        mem_wren   = (state_q == StReq) && we_q;
        resp_valid = (state_q == StDone);
    end

    // Request latch, read-latency countdown, read-data capture and busy flag.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            lat_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && req_valid) begin
                we_q   <= req_we;
                addr_q <= req_addr;
                din_q  <= req_wdata;
            end
            if (state_q == StReq && acq && !we_q) begin
                lat_q <= LatInit;
            end else if (state_q == StLat && lat_q != 2'd0) begin
                lat_q <= lat_q - 2'd1;
            end
            if (state_q == StLat && lat_q == 2'd0) begin
                rdata_q <= mem_q;
            end
            busy_q <= (state_d != StIdle);
        end
    end

    // Saturating stall counter; a clear wins over a same-cycle increment.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (clr_stats) begin
            stall_q <= '0;
        end else if (state_q == StReq && !acq && stall_q != {CW{1'b1}}) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign resp_rdata = rdata_q;
    assign stall_cnt  = stall_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Self-checking bench for mem_port_master: table vectors, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_mem_port_master;

    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam int CW     = 4;
    localparam int SAT    = (1 << CW) - 1;

    logic          CLK;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          acq;
    logic [DW-1:0] mem_q;
    logic          busy;
    logic [CW-1:0] stall_cnt;
    logic          clr_stats;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept at transaction level.
    int            st_model;
    logic [DW-1:0] rd_model;
    logic [DW-1:0] ram [256];

    mem_port_master #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CW(CW)
    ) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .acq        (acq),
        .mem_q      (mem_q),
        .busy       (busy),
        .stall_cnt  (stall_cnt),
        .clr_stats  (clr_stats)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            stalls;
        logic [DW-1:0] q;
        logic [DW-1:0] exp_rdata;
        int            exp_stall;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        check("rden_wren_exclusive", {31'd0, mem_rden & mem_wren}, 32'd0);
    endtask

    // One complete transaction with a given number of refused-grant cycles.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int stalls,
                          input logic [DW-1:0] q, input logic [DW-1:0] exp_rdata,
                          input int exp_stall);
        int   lat;
        int   bcnt;
        int   exp_lat;
        logic seen;
        exp_lat = 2 + stalls + (we ? 0 : RD_LAT);
        check("req_ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        acq       = 1'b0;
        tick();
        lat  = 1;
        bcnt = 0;
        // Request inputs are don't-care while not ready.
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        for (int k = 0; k <= stalls; k++) begin
            mem_q = DW'($urandom);
            check("req_mem_rden", mem_rden, !we);
            check("req_mem_wren", mem_wren, we);
            check("req_mem_addr", mem_addr, addr);
            check("req_mem_din", mem_din, wdata);
            check("req_ready_busy", req_ready, 0);
            check("req_no_resp", resp_valid, 0);
            bcnt += busy;
            acq = (k == stalls);
            tick();
            lat++;
        end
        acq = 1'($urandom);
        if (!we) begin
            for (int j = 1; j <= RD_LAT; j++) begin
                mem_q = (j == RD_LAT) ? q : ~q;
                check("lat_rden_low", mem_rden, 0);
                check("lat_wren_low", mem_wren, 0);
                check("lat_no_resp", resp_valid, 0);
                bcnt += busy;
                tick();
                lat++;
            end
        end
        mem_q = DW'($urandom);
        seen = 1'b0;
        for (int w = 0; w < 8 && !seen; w++) begin
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                bcnt += busy;
                tick();
                lat++;
            end
        end
        check("resp_seen", seen, 1);
        check("latency", lat, exp_lat);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("stall_cnt", stall_cnt, exp_stall);
        bcnt += busy;
        check("busy_cycles", bcnt, exp_lat);
        req_valid = 1'b0;
        acq = 1'($urandom);
        tick();
        check("resp_one_cycle", resp_valid, 0);
        check("idle_busy_low", busy, 0);
        check("idle_ready", req_ready, 1);
        acq = 1'b0;
    endtask

    initial begin
        int nresp;
        int stalls;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        acq       = 1'b0;
        mem_q     = '0;
        clr_stats = 1'b0;

        vecs[0] = '{1'b1, 8'h10, 8'hA5, 0, 8'h00, 8'h00, 0};
        vecs[1] = '{1'b0, 8'h40, 8'h00, 3, 8'h3C, 8'h3C, 3};
        vecs[2] = '{1'b1, 8'h20, 8'h11, 0, 8'h00, 8'h3C, 3};
        vecs[3] = '{1'b0, 8'h20, 8'h00, 0, 8'h11, 8'h11, 3};
        vecs[4] = '{1'b1, 8'h33, 8'h77, 5, 8'hEE, 8'h11, 8};
        vecs[5] = '{1'b0, 8'h7F, 8'h00, 2, 8'hC3, 8'hC3, 10};
        vecs[6] = '{1'b0, 8'h01, 8'h00, 6, 8'h5A, 8'h5A, 15};
        vecs[7] = '{1'b1, 8'hFF, 8'h00, 1, 8'h00, 8'h5A, 15};

        // Reset state.
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rden", mem_rden, 0);
        check("rst_wren", mem_wren, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Table vectors, issued back to back.
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stalls,
                   vecs[i].q, vecs[i].exp_rdata, vecs[i].exp_stall);
        end
        st_model = 15;
        rd_model = 8'h5A;

        // Spurious grant while idle.
        acq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("spur_rden", mem_rden, 0);
            check("spur_wren", mem_wren, 0);
            check("spur_resp", resp_valid, 0);
            check("spur_busy", busy, 0);
            check("spur_stall", stall_cnt, st_model);
        end
        acq = 1'b0;

        // Clear together with a stall cycle, counter already saturated.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h55;
        tick();
        req_valid = 1'b0;
        clr_stats = 1'b1;
        tick();
        check("clr_priority", stall_cnt, 0);
        clr_stats = 1'b0;
        tick();
        check("stall_after_clr", stall_cnt, 1);
        acq = 1'b1;
        tick();
        acq   = 1'b0;
        mem_q = 8'h99;
        tick();
        check("clr_seq_resp", resp_valid, 1);
        check("clr_seq_rdata", resp_rdata, 8'h99);
        tick();
        st_model = 1;
        rd_model = 8'h99;

        // Reset in the middle of a stalled load.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h66;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rden", mem_rden, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 1);
        check("midrst_stall", stall_cnt, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_rdata", resp_rdata, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        nresp = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nresp += resp_valid;
        end
        check("midrst_no_resp", nresp, 0);
        check("midrst_ready_after", req_ready, 1);
        st_model = 0;
        rd_model = '0;

        // Saturation over a long stall, then an idle clear.
        do_txn(1'b1, 8'h80, 8'h42, 20, 8'h00, rd_model, SAT);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("idle_clr", stall_cnt, 0);
        st_model = 0;

        // Randomized transactions against a RAM and counter model.
        for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);
        for (int i = 0; i < 40; i++) begin
            we     = 1'($urandom_range(0, 1));
            a      = AW'($urandom);
            d      = DW'($urandom);
            stalls = $urandom_range(0, 5);
            if (!we) rd_model = ram[a];
            st_model = (st_model + stalls > SAT) ? SAT : st_model + stalls;
            do_txn(we, a, d, stalls, ram[a], rd_model, st_model);
            if (we) ram[a] = d;
            if ($urandom_range(0, 7) == 0) begin
                clr_stats = 1'b1;
                tick();
                clr_stats = 1'b0;
                st_model  = 0;
                check("rand_clr", stall_cnt, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
